// File: rtl/imem_loader.sv
// imem_loader
//
// Byte-serial program loader that sits in front of the RV32 core's instruction
// fetch stage. Program bytes arrive over a valid/ready handshake. They are
// assembled little-endian into 32-bit words, and each word is written to
// consecutive word addresses of instruction memory. The core is held idle until
// the load finishes. A load ends on an all-zero word, which is the core's exit
// encoding, or after INS words.
//
// Parameters
//   INS         maximum number of instruction words per load (1..255)
//
// Ports
//   clk         core clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   start       begin a load (honoured only while idle or done)
//   byte_valid  byte_data carries a valid program byte
//   byte_data   program byte, lowest address first
//   byte_ready  loader accepts a byte this cycle
//   wr_en       instruction-memory write strobe, one cycle per word
//   wr_addr     byte address of the word being written (word index * 4)
//   wr_data     assembled little-endian instruction word
//   busy        load in progress
//   done        load complete
//   core_run    core may execute (mirrors done)
//   word_count  words written in the current or last load

module imem_loader #(
  parameter int INS = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        core_run,
  output logic [7:0]  word_count
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } state_t;

  // Index of the final word a load may write before it is forced to finish.
  localparam logic [7:0] LastIdx = 8'(INS - 1);

  state_t      state_q;
  logic [1:0]  byteIdx_q;
  // Only the three lower bytes are kept. The top byte goes straight from
  // byte_data into the write register.
  logic [23:0] asm_q;
  // The word count also serves as the word index, because the two always
  // advance together.
  logic [7:0]  wordCount_q;
  logic [31:0] wrAddr_q;
  logic [31:0] wrData_q;
  logic        byteReady_q;
  logic        wrEn_q;
  logic        busy_q;
  logic        done_q;

  // Loader FSM. Every output is a register that is updated together with the
  // state, so no input reaches an output combinationally. wr_addr and wr_data
  // are loaded on the edge that enters WRITE, and they keep that value until
  // the next word completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      byteIdx_q   <= 2'd0;
      asm_q       <= 24'd0;
      wordCount_q <= 8'd0;
      wrAddr_q    <= 32'd0;
      wrData_q    <= 32'd0;
      byteReady_q <= 1'b0;
      wrEn_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q     <= COLLECT;
            byteIdx_q   <= 2'd0;
            asm_q       <= 24'd0;
            wordCount_q <= 8'd0;
            byteReady_q <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
          end
        end

        COLLECT: begin
          // byte_ready is always high here, so byte_valid alone completes
          // the handshake.
          if (byte_valid) begin
            byteIdx_q <= byteIdx_q + 2'd1;
            case (byteIdx_q)
              2'd0: asm_q[7:0]   <= byte_data;
              2'd1: asm_q[15:8]  <= byte_data;
              2'd2: asm_q[23:16] <= byte_data;
              default: begin
                state_q     <= WRITE;
                byteReady_q <= 1'b0;
                wrEn_q      <= 1'b1;
                wrAddr_q    <= {22'd0, wordCount_q, 2'b00};
                wrData_q    <= {byte_data, asm_q};
              end
            endcase
          end
        end

        WRITE: begin
          // The terminator word is still written and counted before the
          // load finishes.
          wrEn_q      <= 1'b0;
          wordCount_q <= wordCount_q + 8'd1;
          if (wrData_q == 32'd0 || wordCount_q == LastIdx) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q     <= COLLECT;
            byteReady_q <= 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign byte_ready = byteReady_q;
  assign wr_en      = wrEn_q;
  assign wr_addr    = wrAddr_q;
  assign wr_data    = wrData_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign core_run   = done_q;
  assign word_count = wordCount_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//
// Drives two loaders with the same byte stream. Instance 0 has a word limit of
// five and instance 1 has a limit of two. A transaction-level model follows
// each instance using counters, and the outputs are compared against it on
// every falling clock edge. Literal expectations for the write log, the counts
// and the reset values pin down the model itself.

module tb_imem_loader;

  localparam int InsA = 5;
  localparam int InsB = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        byteValid;
  logic [7:0]  byteData;
  logic [1:0]  byteReady, wrEn, busy, done, coreRun;
  logic [31:0] wrAddr [2];
  logic [31:0] wrData [2];
  logic [7:0]  wordCount [2];

  int checks = 0;
  int failures = 0;

  // Write logs, captured from the DUT strobes.
  logic [31:0] logAddr0[$], logData0[$], logAddr1[$], logData1[$];

  // Model state per instance: loading, in a write cycle, finished, and the
  // byte and word progress.
  bit          mActive [2] = '{0, 0};
  bit          mWrite  [2] = '{0, 0};
  bit          mDone   [2] = '{0, 0};
  int unsigned mBytes  [2] = '{0, 0};
  int unsigned mCount  [2] = '{0, 0};
  logic [31:0] mWord   [2] = '{32'd0, 32'd0};
  logic [31:0] mAddr   [2] = '{32'd0, 32'd0};
  logic [31:0] mData   [2] = '{32'd0, 32'd0};

  imem_loader #(.INS(InsA)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byteValid),
    .byte_data(byteData), .byte_ready(byteReady[0]), .wr_en(wrEn[0]),
    .wr_addr(wrAddr[0]), .wr_data(wrData[0]), .busy(busy[0]),
    .done(done[0]), .core_run(coreRun[0]), .word_count(wordCount[0])
  );

  imem_loader #(.INS(InsB)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byteValid),
    .byte_data(byteData), .byte_ready(byteReady[1]), .wr_en(wrEn[1]),
    .wr_addr(wrAddr[1]), .wr_data(wrData[1]), .busy(busy[1]),
    .done(done[1]), .core_run(coreRun[1]), .word_count(wordCount[1])
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  function automatic int unsigned insOf(input int k);
    return (k == 0) ? InsA : InsB;
  endfunction

  task automatic checkOutput(input string name, input int k,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s[%0d] got=0x%08h expected=0x%08h at %0t",
               name, k, act, exp, $time);
    end
  endtask

  // Model step. A write cycle always ends one edge later, and its word counts.
  // Collection accepts any valid byte. Idle or done restarts on start.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        mActive[k] = 0; mWrite[k] = 0; mDone[k] = 0;
        mBytes[k] = 0; mCount[k] = 0;
        mWord[k] = 32'd0; mAddr[k] = 32'd0; mData[k] = 32'd0;
      end else if (mWrite[k]) begin
        mWrite[k] = 0;
        mCount[k] = mCount[k] + 1;
        if (mData[k] == 32'd0 || mCount[k] == insOf(k)) begin
          mActive[k] = 0;
          mDone[k] = 1;
        end
      end else if (mActive[k]) begin
        if (byteValid) begin
          mWord[k] = mWord[k] | (32'(byteData) << (8 * mBytes[k]));
          mBytes[k] = mBytes[k] + 1;
          if (mBytes[k] == 4) begin
            mData[k] = mWord[k];
            mAddr[k] = 32'(4 * mCount[k]);
            mWrite[k] = 1;
            mBytes[k] = 0;
            mWord[k] = 32'd0;
          end
        end
      end else if (start) begin
        mActive[k] = 1; mDone[k] = 0;
        mCount[k] = 0; mBytes[k] = 0; mWord[k] = 32'd0;
      end
    end
  end

  // Per-cycle comparison against the model, plus write-log capture.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      checkOutput("byte_ready", k, 32'(byteReady[k]), 32'(mActive[k] && !mWrite[k]));
      checkOutput("wr_en",      k, 32'(wrEn[k]),      32'(mWrite[k]));
      checkOutput("busy",       k, 32'(busy[k]),      32'(mActive[k]));
      checkOutput("done",       k, 32'(done[k]),      32'(mDone[k]));
      checkOutput("core_run",   k, 32'(coreRun[k]),   32'(mDone[k]));
      checkOutput("word_count", k, 32'(wordCount[k]), mCount[k]);
      checkOutput("wr_addr",    k, wrAddr[k],         mAddr[k]);
      checkOutput("wr_data",    k, wrData[k],         mData[k]);
    end
    if (wrEn[0] === 1'b1) begin logAddr0.push_back(wrAddr[0]); logData0.push_back(wrData[0]); end
    if (wrEn[1] === 1'b1) begin logAddr1.push_back(wrAddr[1]); logData1.push_back(wrData[1]); end
  end

  task automatic clearLogs();
    logAddr0.delete(); logData0.delete(); logAddr1.delete(); logData1.delete();
  endtask

  task automatic checkLog(input int k, input int idx,
                          input logic [31:0] expAddr, input logic [31:0] expData);
    logic [31:0] a, d;
    a = 32'hDEAD_BEEF;
    d = 32'hDEAD_BEEF;
    if (k == 0 && idx < logAddr0.size()) begin a = logAddr0[idx]; d = logData0[idx]; end
    if (k == 1 && idx < logAddr1.size()) begin a = logAddr1[idx]; d = logData1[idx]; end
    checkOutput($sformatf("log_addr%0d", idx), k, a, expAddr);
    checkOutput($sformatf("log_data%0d", idx), k, d, expData);
  endtask

  // Presents one byte after an idle gap and holds it until instance 0 takes
  // it. Returns one unit after the accepting edge.
  task automatic applyStimulus(input logic [7:0] d, input int gap);
    bit accepted;
    byteValid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    byteValid = 1'b1;
    byteData = d;
    accepted = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (byteReady[0]) begin accepted = 1; break; end
    end
    @(posedge clk); #1;
    byteValid = 1'b0;
    checkOutput("byte_accept", 0, 32'(accepted), 32'd1);
  endtask

  task automatic sendWord(input logic [31:0] w, input bit randomGaps);
    for (int b = 0; b < 4; b++)
      applyStimulus(w[8*b +: 8], randomGaps ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic startLoad();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int k);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (done[k]) break;
    end
    checkOutput("done_wait", k, 32'(done[k]), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation watchdog");
  end

  logic [31:0] prog [3];

  initial begin
    prog[0] = 32'h00A0_0093;
    prog[1] = 32'h0010_8113;
    prog[2] = 32'h0000_0FFF;
    rst_n = 1'b0; start = 1'b0; byteValid = 1'b0; byteData = 8'd0;

    // Reset, then idle with start low.
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput("idle_busy", k, 32'(busy[k]), 32'd0);
      checkOutput("idle_done", k, 32'(done[k]), 32'd0);
      checkOutput("idle_count", k, 32'(wordCount[k]), 32'd0);
    end

    // Single word followed by the terminator.
    $display("[TB] single word + terminator");
    startLoad();
    checkOutput("start_busy", 0, 32'(busy[0]), 32'd1);
    checkOutput("start_ready", 0, 32'(byteReady[0]), 32'd1);
    sendWord(32'h0050_0513, 0);
    sendWord(32'h0000_0000, 0);
    waitDone(0);
    checkOutput("log_size", 0, 32'(logAddr0.size()), 32'd2);
    checkLog(0, 0, 32'h0, 32'h0050_0513);
    checkLog(0, 1, 32'h4, 32'h0000_0000);
    checkOutput("final_count", 0, 32'(wordCount[0]), 32'd2);
    checkOutput("model_count", 0, mCount[0], 32'd2);
    checkOutput("final_done", 1, 32'(done[1]), 32'd1);
    clearLogs();

    // Restart from done, then the word limit with gapped bytes.
    $display("[TB] restart + word limit + gaps");
    startLoad();
    for (int k = 0; k < 2; k++) begin
      checkOutput("restart_done", k, 32'(done[k]), 32'd0);
      checkOutput("restart_run", k, 32'(coreRun[k]), 32'd0);
      checkOutput("restart_count", k, 32'(wordCount[k]), 32'd0);
    end
    for (int i = 0; i < 3; i++) sendWord(prog[i], 1'b1);
    sendWord(32'h0000_0000, 1'b1);
    waitDone(0);
    checkOutput("limit_log_size", 1, 32'(logAddr1.size()), 32'd2);
    checkLog(1, 0, 32'h0, prog[0]);
    checkLog(1, 1, 32'h4, prog[1]);
    checkOutput("limit_count", 1, 32'(wordCount[1]), 32'd2);
    checkOutput("limit_ready", 1, 32'(byteReady[1]), 32'd0);
    checkOutput("full_log_size", 0, 32'(logAddr0.size()), 32'd4);
    checkLog(0, 2, 32'h8, prog[2]);
    checkLog(0, 3, 32'hC, 32'h0);
    checkOutput("full_count", 0, 32'(wordCount[0]), 32'd4);
    clearLogs();

    // Reset in the middle of a word.
    $display("[TB] reset mid-load");
    startLoad();
    applyStimulus(8'h37, 0);
    applyStimulus(8'h41, 1);
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput("rst_ready", k, 32'(byteReady[k]), 32'd0);
      checkOutput("rst_busy", k, 32'(busy[k]), 32'd0);
      checkOutput("rst_wr_en", k, 32'(wrEn[k]), 32'd0);
      checkOutput("rst_wr_addr", k, wrAddr[k], 32'd0);
      checkOutput("rst_wr_data", k, wrData[k], 32'd0);
      checkOutput("rst_done", k, 32'(done[k]), 32'd0);
      checkOutput("rst_count", k, 32'(wordCount[k]), 32'd0);
    end
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    checkOutput("rst_no_write", 0, 32'(logAddr0.size()), 32'd0);
    checkOutput("rst_idle", 0, 32'(busy[0]), 32'd0);
    startLoad();
    sendWord(32'h0002_4137, 1'b1);
    sendWord(32'h0000_0000, 1'b0);
    waitDone(0);
    checkLog(0, 0, 32'h0, 32'h0002_4137);
    checkLog(1, 0, 32'h0, 32'h0002_4137);
    checkOutput("reload_count", 0, 32'(wordCount[0]), 32'd2);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-serial program loader that sits directly upstream of the RV32 core's instruction fetch stage. It accepts a stream of program bytes over a valid/ready handshake and assembles them little-endian into 32-bit words. It writes each word into instruction memory at consecutive word addresses and holds the core idle until the program is loaded. Loading ends on an all-zero word (the core's exit encoding) or after INS words.

## Interface
- INS, 5, maximum number of instruction words loaded; legal range 1..255

- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a load; sampled only in IDLE or DONE
- byte_valid  in  1  byte_data holds a valid program byte
- byte_data  in  8  program byte, lowest address first
- byte_ready  out  1  loader accepts a byte this cycle
- wr_en  out  1  instruction-memory write strobe, one cycle per word
- wr_addr  out  32  byte address of the word being written (word_idx*4)
- wr_data  out  32  assembled little-endian instruction word
- busy  out  1  load in progress (COLLECT or WRITE)
- done  out  1  load complete
- core_run  out  1  core may execute; equals done
- word_count  out  8  number of words written in the current/last load

## Operation
- Reset (async, rst_n=0) forces: state=IDLE, byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, core_run=0, word_count=0, byte index=0, word index=0.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE: byte_ready=0. If start=1, go to COLLECT and clear byte index, word index, word_count and the assembly register.
- COLLECT: byte_ready=1. A byte transfers when byte_valid&byte_ready at a rising edge. Byte index n (0..3) goes to bits [8n+7:8n]. The byte index increments and wraps 3->0. On the 4th transfer, go to WRITE. Without byte_valid, the state holds indefinitely.
- WRITE: byte_ready=0, wr_en=1, wr_addr={word_idx,2'b00} zero-extended, wr_data=assembled word. word_count increments at the end of this cycle and word_idx increments.
  - Exit to DONE if the assembled word==32'h00000000; the terminator is still written and counted.
  - Exit to DONE if word_idx==INS-1.
  - Otherwise return to COLLECT.
- DONE: done=1, core_run=1, byte_ready=0. Extra bytes are never accepted. start=1 restarts exactly as from IDLE, and done/core_run drop in the next cycle.
- start is ignored in COLLECT and WRITE.
- busy=1 exactly in COLLECT and WRITE.
- Reset mid-load: the partial word is discarded and no wr_en is issued. Memory contents already written are not the loader's concern.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- start high at edge t puts busy and byte_ready high in cycle t+1.
- When the 4th byte of a word is accepted at edge k, wr_en is high for exactly the cycle after edge k.
  - With byte_valid held high, byte_ready rises again in the cycle after that.
  - Minimum throughput is 5 cycles per word.
- done/core_run rise in the cycle after the final WRITE cycle.
- wr_addr and wr_data are stable for the entire wr_en cycle. Outside WRITE they hold their last values.
- word_count is updated by the edge that ends the WRITE cycle.

## Test plan
- Reset values: assert rst_n=0 mid-cycle. All outputs are 0 immediately (async), and they remain 0 after release with start=0.
- Single word + terminator (INS=5): start, then bytes 13 05 50 00, then 00 00 00 00 -> writes 0x00500513@0x0 and 0x00000000@0x4, word_count=2, done=1.
- INS limit (INS=2): stream 3 nonzero words -> exactly 2 wr_en pulses (addr 0x0, 0x4), done=1, byte_ready=0 thereafter, 3rd word never accepted.
- Backpressure/gaps: byte_valid toggled randomly -> assembled words are unchanged. Each wr_en is exactly one cycle, and byte_ready=0 during every WRITE cycle.
- Reset mid-load: after 2 bytes of word 1, pulse rst_n=0 -> no wr_en, state IDLE. A new load writes its first word to 0x0 with correct data.
- Restart from DONE: after a completed load, pulse start -> done drops next cycle, word_count=0, and the new program is written from 0x0.
